// File: rtl/fma_pio_engine_if.sv
// Operand/result handshake bundle for the multiply/accumulate engine.
// The master side drives operands and pops results; the slave is the engine.
interface fma_pio_engine_if #(
    parameter int DATA_W     = 8,
    parameter int RES_W      = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [1:0]        op_mode;
    logic              op_valid;
    logic              op_ready;
    logic [RES_W-1:0]  res_data;
    logic              res_ovf;
    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  acc_value;
    logic              sticky_ovf;
    logic [LVL_W-1:0]  fifo_level;
    logic              busy;

    modport master (
        output op_a, op_b, op_mode, op_valid, res_ready,
        input  op_ready, res_data, res_ovf, res_valid,
        input  acc_value, sticky_ovf, fifo_level, busy
    );

    modport slave (
        input  op_a, op_b, op_mode, op_valid, res_ready,
        output op_ready, res_data, res_ovf, res_valid,
        output acc_value, sticky_ovf, fifo_level, busy
    );
endinterface

// File: rtl/fma_pio_engine.sv
// Multiply/accumulate engine: one operand stage, saturating accumulator,
// and a show-ahead result FIFO with per-entry overflow flags.
module fma_pio_engine #(
    parameter int DATA_W     = 8,
    parameter int RES_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SIGNED     = 0
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    fma_pio_engine_if.slave   bus
);
    localparam int PW = 2 * DATA_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [RES_W-1:0] SMAX = {1'b0, {(RES_W-1){1'b1}}};
    localparam logic [RES_W-1:0] SMIN = {1'b1, {(RES_W-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_MUL  = 2'b00,
        MODE_MAC  = 2'b01,
        MODE_MSUB = 2'b10,
        MODE_CLR  = 2'b11
    } mode_e;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    mode_e             s1_mode;
    logic [RES_W-1:0]  acc;
    logic              sticky;

    logic [RES_W-1:0]  mem_data [FIFO_DEPTH];
    logic              mem_ovf  [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;

    logic              accept;
    logic              push;
    logic              pop;
    logic [LW:0]       pending;

    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     b_ext;
    logic [PW-1:0]     prod;
    logic [RES_W:0]    p_ext;
    logic [RES_W:0]    acc_ext;
    logic [RES_W:0]    x;
    logic [RES_W-1:0]  r;
    logic              ovf;

    // Ready depends only on registered occupancy, never on res_ready.
    assign pending = {1'b0, level} + {{LW{1'b0}}, s1_valid};
    assign bus.op_ready = pending < (LW+1)'(FIFO_DEPTH);
    assign accept = bus.op_valid & bus.op_ready;
    assign push   = s1_valid;
    assign pop    = bus.res_valid & bus.res_ready;

    assign bus.res_valid  = level != '0;
    assign bus.res_data   = bus.res_valid ? mem_data[rd_ptr] : '0;
    assign bus.res_ovf    = bus.res_valid ? mem_ovf[rd_ptr] : 1'b0;
    assign bus.acc_value  = acc;
    assign bus.sticky_ovf = sticky;
    assign bus.fifo_level = level;
    assign bus.busy       = s1_valid | bus.res_valid;

    // Low PW bits of a PW x PW product are correct for both signednesses.
    always_comb begin
        a_ext   = {{DATA_W{(SIGNED != 0) & s1_a[DATA_W-1]}}, s1_a};
        b_ext   = {{DATA_W{(SIGNED != 0) & s1_b[DATA_W-1]}}, s1_b};
        prod    = a_ext * b_ext;
        p_ext   = {{(RES_W+1-PW){(SIGNED != 0) & prod[PW-1]}}, prod};
        acc_ext = {(SIGNED != 0) & acc[RES_W-1], acc};
        x       = '0;
        r       = '0;
        ovf     = 1'b0;
        unique case (s1_mode)
            MODE_MUL: r = p_ext[RES_W-1:0];
            MODE_MAC, MODE_MSUB: begin
                x = (s1_mode == MODE_MAC) ? acc_ext + p_ext
                                          : acc_ext - p_ext;
                if (SIGNED != 0) begin
                    ovf = x[RES_W] ^ x[RES_W-1];
                    r   = ovf ? (x[RES_W] ? SMIN : SMAX) : x[RES_W-1:0];
                end else begin
                    ovf = x[RES_W];
                    if (!ovf)
                        r = x[RES_W-1:0];
                    else if (s1_mode == MODE_MAC)
                        r = '1;
                    else
                        r = '0;
                end
            end
            MODE_CLR: r = '0;
            default:  r = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= MODE_MUL;
            acc      <= '0;
            sticky   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= bus.op_a;
                s1_b     <= bus.op_b;
                s1_mode  <= mode_e'(bus.op_mode);
            end else begin
                s1_valid <= 1'b0;
            end
            if (s1_valid) begin
                acc <= r;
                if (s1_mode == MODE_CLR)
                    sticky <= 1'b0;
                else if (ovf)
                    sticky <= 1'b1;
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: outputs are gated by res_valid.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem_data[wr_ptr] <= r;
            mem_ovf[wr_ptr]  <= ovf;
        end
    end
endmodule

// File: tb/tb_fma_pio_engine.sv
// Scoreboard bench for the multiply/accumulate engine, unsigned and
// signed instances side by side.
module tb_fma_pio_engine;
    typedef struct packed {
        logic        ovf;
        logic [15:0] data;
    } exp_t;

    localparam logic [1:0] MUL  = 2'b00;
    localparam logic [1:0] MAC  = 2'b01;
    localparam logic [1:0] MSUB = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    exp_t qu[$];
    exp_t qs[$];

    always #5 clk = ~clk;

    fma_pio_engine_if #(.DATA_W(8), .RES_W(16), .FIFO_DEPTH(4)) u_if ();
    fma_pio_engine_if #(.DATA_W(8), .RES_W(16), .FIFO_DEPTH(4)) s_if ();

    fma_pio_engine #(.DATA_W(8), .RES_W(16), .FIFO_DEPTH(4), .SIGNED(0)) u_dut (
        .clk_clk(clk), .reset_reset(rst), .bus(u_if.slave)
    );
    fma_pio_engine #(.DATA_W(8), .RES_W(16), .FIFO_DEPTH(4), .SIGNED(1)) s_dut (
        .clk_clk(clk), .reset_reset(rst), .bus(s_if.slave)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: a pop happens on the next edge when valid&ready mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && u_if.res_valid && u_if.res_ready) begin
            checks++;
            if (qu.size() == 0) begin
                failures++;
                $display("FAIL u_unexpected: got %0h/%0b expected none",
                         u_if.res_data, u_if.res_ovf);
            end else begin
                e = qu.pop_front();
                if ({u_if.res_ovf, u_if.res_data} !== e) begin
                    failures++;
                    $display("FAIL u_result: got %0h/%0b expected %0h/%0b",
                             u_if.res_data, u_if.res_ovf, e.data, e.ovf);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && s_if.res_valid && s_if.res_ready) begin
            checks++;
            if (qs.size() == 0) begin
                failures++;
                $display("FAIL s_unexpected: got %0h/%0b expected none",
                         s_if.res_data, s_if.res_ovf);
            end else begin
                e = qs.pop_front();
                if ({s_if.res_ovf, s_if.res_data} !== e) begin
                    failures++;
                    $display("FAIL s_result: got %0h/%0b expected %0h/%0b",
                             s_if.res_data, s_if.res_ovf, e.data, e.ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves op_valid high so consecutive calls stream one op per cycle.
    task automatic send_u(input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] m, input logic [15:0] r,
                          input logic o);
        logic rdy;
        int n = 0;
        u_if.op_a = a;
        u_if.op_b = b;
        u_if.op_mode = m;
        u_if.op_valid = 1'b1;
        do begin
            rdy = u_if.op_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        if (rdy) qu.push_back({o, r});
        else chk("u_send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_s(input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] m, input logic [15:0] r,
                          input logic o);
        logic rdy;
        int n = 0;
        s_if.op_a = a;
        s_if.op_b = b;
        s_if.op_mode = m;
        s_if.op_valid = 1'b1;
        do begin
            rdy = s_if.op_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        if (rdy) qs.push_back({o, r});
        else chk("s_send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        u_if.op_valid = 1'b0;
        s_if.op_valid = 1'b0;
        u_if.res_ready = 1'b1;
        s_if.res_ready = 1'b1;
        while ((qu.size() != 0 || qs.size() != 0 || u_if.busy || s_if.busy)
               && n < 100) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(qu.size() + qs.size()), 32'd0);
    endtask

    initial begin
        int idx;
        int acc_cyc[6];
        logic rdy;

        u_if.op_a = '0; u_if.op_b = '0; u_if.op_mode = MUL;
        u_if.op_valid = 1'b0; u_if.res_ready = 1'b0;
        s_if.op_a = '0; s_if.op_b = '0; s_if.op_mode = MUL;
        s_if.op_valid = 1'b0; s_if.res_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_res_valid", 32'(u_if.res_valid), 32'd0);
        chk("rst_res_data", 32'(u_if.res_data), 32'd0);
        chk("rst_res_ovf", 32'(u_if.res_ovf), 32'd0);
        chk("rst_acc", 32'(u_if.acc_value), 32'd0);
        chk("rst_level", 32'(u_if.fifo_level), 32'd0);
        chk("rst_busy", 32'(u_if.busy), 32'd0);
        chk("rst_op_ready", 32'(u_if.op_ready), 32'd1);
        chk("rst_sticky", 32'(u_if.sticky_ovf), 32'd0);

        // Three queued results plus one op in s1, then a one-cycle reset.
        send_u(8'd3, 8'd4, MUL, 16'd12, 1'b0);
        send_u(8'd5, 8'd6, MUL, 16'd30, 1'b0);
        send_u(8'd7, 8'd8, MUL, 16'd56, 1'b0);
        send_u(8'd9, 8'd9, MUL, 16'd81, 1'b0);
        u_if.op_valid = 1'b0;
        chk("pre_rst_level", 32'(u_if.fifo_level), 32'd3);
        chk("pre_rst_op_ready", 32'(u_if.op_ready), 32'd0);
        chk("pre_rst_acc", 32'(u_if.acc_value), 32'd56);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        qu.delete();
        qs.delete();
        chk("mid_rst_level", 32'(u_if.fifo_level), 32'd0);
        chk("mid_rst_valid", 32'(u_if.res_valid), 32'd0);
        chk("mid_rst_acc", 32'(u_if.acc_value), 32'd0);
        tick();
        chk("mid_rst_busy", 32'(u_if.busy), 32'd0);
        chk("mid_rst_acc2", 32'(u_if.acc_value), 32'd0);

        // MUL latency: visible one edge after acceptance.
        u_if.res_ready = 1'b1;
        send_u(8'd200, 8'd200, MUL, 16'd40000, 1'b0);
        u_if.op_valid = 1'b0;
        tick();
        chk("mul_res_valid", 32'(u_if.res_valid), 32'd1);
        chk("mul_res_data", 32'(u_if.res_data), 32'd40000);
        chk("mul_res_ovf", 32'(u_if.res_ovf), 32'd0);
        chk("mul_acc", 32'(u_if.acc_value), 32'd40000);
        drain();

        // Accumulate into saturation, then clear.
        send_u(8'd0, 8'd0, CLR, 16'd0, 1'b0);
        send_u(8'd255, 8'd255, MAC, 16'd65025, 1'b0);
        send_u(8'd255, 8'd255, MAC, 16'd65535, 1'b1);
        u_if.op_valid = 1'b0;
        tick();
        chk("mac_sticky", 32'(u_if.sticky_ovf), 32'd1);
        chk("mac_acc", 32'(u_if.acc_value), 32'd65535);
        send_u(8'd0, 8'd0, CLR, 16'd0, 1'b0);
        u_if.op_valid = 1'b0;
        tick();
        chk("clr_sticky", 32'(u_if.sticky_ovf), 32'd0);
        chk("clr_acc", 32'(u_if.acc_value), 32'd0);

        // Unsigned underflow clips to zero.
        send_u(8'd2, 8'd5, MUL, 16'd10, 1'b0);
        send_u(8'd4, 8'd4, MSUB, 16'd0, 1'b1);
        u_if.op_valid = 1'b0;
        tick();
        chk("msub_acc", 32'(u_if.acc_value), 32'd0);
        chk("msub_sticky", 32'(u_if.sticky_ovf), 32'd1);

        // Signed instance: positive clip, negative product, negative clip.
        send_s(8'h00, 8'h00, CLR, 16'h0000, 1'b0);
        send_s(8'h80, 8'h80, MAC, 16'h4000, 1'b0);
        send_s(8'h80, 8'h80, MAC, 16'h7FFF, 1'b1);
        send_s(8'h80, 8'h7F, MUL, 16'hC080, 1'b0);
        send_s(8'h80, 8'h80, MSUB, 16'h8080, 1'b0);
        send_s(8'h80, 8'h80, MSUB, 16'h8000, 1'b1);
        s_if.op_valid = 1'b0;
        tick();
        chk("s_acc", 32'(s_if.acc_value), 32'h8000);
        chk("s_sticky", 32'(s_if.sticky_ovf), 32'd1);
        drain();

        // Backpressure: six ops offered, only four fit.
        u_if.res_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            u_if.op_a = 8'(idx + 1);
            u_if.op_b = 8'd3;
            u_if.op_mode = MUL;
            u_if.op_valid = 1'b1;
            rdy = u_if.op_ready;
            tick();
            if (rdy) begin
                qu.push_back({1'b0, 16'((idx + 1) * 3)});
                acc_cyc[idx] = c;
                idx++;
            end
        end
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_op_ready", 32'(u_if.op_ready), 32'd0);
        chk("bp_level", 32'(u_if.fifo_level), 32'd4);
        u_if.res_ready = 1'b1;
        for (int c = 8; c < 30 && idx < 6; c++) begin
            u_if.op_a = 8'(idx + 1);
            u_if.op_b = 8'd3;
            rdy = u_if.op_ready;
            tick();
            if (rdy) begin
                qu.push_back({1'b0, 16'((idx + 1) * 3)});
                acc_cyc[idx] = c;
                idx++;
            end
        end
        u_if.op_valid = 1'b0;
        chk("bp_all_accepted", 32'(idx), 32'd6);
        if (idx == 6)
            chk("bp_back_to_back", 32'(acc_cyc[5] - acc_cyc[4]), 32'd1);
        chk("bp_level_steady0", 32'(u_if.fifo_level), 32'd2);
        tick();
        chk("bp_level_steady1", 32'(u_if.fifo_level), 32'd2);
        drain();
        chk("end_busy", 32'(u_if.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fma_pio_engine.md
Name: fma_pio_engine

Overview:
Parametrised multiply/accumulate engine between the HPS PIO operand exports and the PIO result import. It accepts operand pairs via a valid/ready handshake and computes MUL, MAC, MSUB or CLR against an internal saturating accumulator. Results are buffered in a show-ahead result FIFO with per-result overflow flags. Successor to the fixed 8-bit x 8-bit -> 16-bit PIO datapath; it adds parametrised widths, signedness, op modes, accumulation, saturation and backpressure.

Parameters:
DATA_W, 8, operand width (bits)
RES_W, 16, result/accumulator width; must be >= 2*DATA_W
FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2
SIGNED, 0, 0 = unsigned arithmetic, 1 = two's-complement arithmetic

Ports:
clk_clk  in  1  single clock, all logic rising-edge
reset_reset  in  1  synchronous active-high reset
op_a  in  DATA_W  operand A
op_b  in  DATA_W  operand B
op_mode  in  2  00 MUL, 01 MAC, 10 MSUB, 11 CLR
op_valid  in  1  operand pair valid
op_ready  out  1  engine can accept
res_data  out  RES_W  FIFO head result
res_ovf  out  1  FIFO head result was saturated
res_valid  out  1  FIFO non-empty
res_ready  in  1  consumer pops head
acc_value  out  RES_W  live accumulator register
sticky_ovf  out  1  any saturation since last CLR/reset
fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
busy  out  1  s1_valid | res_valid

Behaviour:
- Reset (sync, active-high): acc, s1 stage, FIFO pointers/level, sticky_ovf all cleared. After reset: res_valid=0, res_data=0, res_ovf=0, acc_value=0, fifo_level=0, busy=0, op_ready=1. A reset asserted mid-operation discards the in-flight op and all FIFO contents.
- Accept: a transfer occurs on an edge where op_valid & op_ready. op_a, op_b and op_mode are registered into stage s1, and s1_valid is set.
- op_ready = (fifo_level + s1_valid) < FIFO_DEPTH. It is a function of registers only; there is no combinational path from res_ready or op_valid.
- Execute (edge after s1_valid): p = a*b, 2*DATA_W bits, signed or unsigned per SIGNED, extended to RES_W.
  - MUL: r = p; acc <= r.
  - MAC: r = sat(acc + p); acc <= r.
  - MSUB: r = sat(acc - p); acc <= r.
  - CLR: r = 0; acc <= 0; sticky_ovf <= 0.
- On the execute edge, {r, ovf} is pushed into the FIFO and s1_valid clears, unless a new op is accepted on the same edge; back-to-back ops at 1/cycle are supported.
- Saturation, computed at RES_W+1 bits:
  - Unsigned: overflow clips to 2^RES_W-1; underflow (MSUB) clips to 0.
  - Signed: clips to +2^(RES_W-1)-1 or -2^(RES_W-1).
  - ovf=1 when clipping occurs, and sticky_ovf is set on that edge.
  - MUL never saturates because RES_W >= 2*DATA_W.
- Ordering: ops execute strictly in acceptance order. The accumulator is read and written only at execute, so there are no hazards between consecutive MACs.
- Latency: op accepted on edge k -> acc_value updated and result at FIFO tail after edge k+1. If the FIFO was empty, res_valid=1 and res_data=r are visible after edge k+1.
- FIFO: show-ahead; res_data/res_ovf always reflect the head. The head is popped on an edge where res_valid & res_ready.
  - Push and pop on the same edge: level unchanged; a push to an empty FIFO is never popped on the same edge.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible by construction of op_ready.
- res_ready while empty has no effect. op_valid while op_ready=0 is held off; the operands are not captured.
- acc_value reflects the accumulator register directly, with no FIFO delay.

Test Plan:
1. Reset with res_ready=0, op_valid=0 -> all outputs 0, op_ready=1. Assert reset for 1 cycle while 3 results are queued and one op is in s1 -> fifo_level=0, res_valid=0, acc_value=0 on the following cycle.
2. Defaults, MUL a=200 b=200 accepted on edge k -> res_valid=1 and res_data=40000 (0x9C40), res_ovf=0 after edge k+1; acc_value=40000.
3. CLR, then MAC 255*255, MAC 255*255 -> results 0, 65025, 65535. The last result has res_ovf=1, and sticky_ovf=1. A following CLR -> sticky_ovf=0, acc_value=0.
4. MUL 2*5, then MSUB 4*4 -> results 10, 0 with res_ovf=1 (underflow clip).
5. SIGNED=1: CLR, MAC (-128)*(-128), MAC (-128)*(-128) -> 16384, then 32767 with res_ovf=1. MUL (-128)*127 -> -16256 (0xC080).
6. Backpressure: res_ready=0, op_valid held high with 6 ops -> exactly 4 accepted, op_ready=0, fifo_level=4. Then res_ready=1 -> results drain in order. Acceptance resumes once (fifo_level+s1_valid)<4, sustaining 1 op/cycle with simultaneous push/pop and fifo_level steady.
